// File: rtl/eth_pkg.sv
// eth_pkg: shared state encoding, status codes and protocol constants
// for the Ethernet II receive parser.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_HDR  = 3'd2,
        ST_DATA = 3'd3,
        ST_END  = 3'd4,
        ST_DROP = 3'd5
    } rx_state_e;

    localparam logic [2:0] CODE_OK       = 3'd0;
    localparam logic [2:0] CODE_RUNT     = 3'd1;
    localparam logic [2:0] CODE_TOO_LONG = 3'd2;
    localparam logic [2:0] CODE_PHY_ERR  = 3'd3;
    localparam logic [2:0] CODE_FCS_ERR  = 3'd4;

    localparam int ETH_HDR_LEN   = 14;
    localparam int ETH_MAC_LEN   = 6;
    localparam int ETH_FCS_LEN   = 4;
    localparam int ETH_DLY_DEPTH = ETH_FCS_LEN + 1;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_POLY_R  = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
    localparam logic [47:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/eth_crc32_byte.sv
// eth_crc32_byte: combinational reflected CRC-32 update for one byte,
// LSB of the byte first.
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i ^ {24'h0, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_R) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/eth_rx_frame_parser.sv
// eth_rx_frame_parser: Ethernet II RX parser (preamble strip, dest filter,
// FCS strip, status + stats). Define ETH_RX_FCS_CHECK_EN to add CRC-32 check.
module eth_rx_frame_parser
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC     = 48'h0200_0000_0001,
    parameter bit          ACCEPT_BCAST  = 1'b1,
    parameter int          MIN_FRAME_LEN = 64,
    parameter int          MAX_FRAME_LEN = 1518,
    parameter int          CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_dv_i,
    input  logic             rx_err_i,
    input  logic             rx_enable_i,
    input  logic             promisc_en_i,
    output logic [7:0]       out_data_o,
    output logic             out_valid_o,
    output logic             out_last_o,
    output logic             status_valid_o,
    output logic [2:0]       status_code_o,
    output logic [10:0]      frame_len_o,
    output logic [47:0]      dest_mac_o,
    output logic [47:0]      src_mac_o,
    output logic [15:0]      eth_type_o,
    output logic [CNT_W-1:0] cnt_good_o,
    output logic [CNT_W-1:0] cnt_bad_o,
    output logic [CNT_W-1:0] cnt_filt_o
);

    localparam logic [10:0] MIN_L     = 11'(MIN_FRAME_LEN);
    localparam logic [10:0] MAX_L     = 11'(MAX_FRAME_LEN);
    localparam logic [10:0] LEN_SAT   = 11'h7FF;
    localparam logic [10:0] LEN_DEST  = 11'(ETH_MAC_LEN - 1);
    localparam logic [10:0] LEN_HDR   = 11'(ETH_HDR_LEN - 1);
    localparam logic [2:0]  DLY_FULL  = 3'(ETH_DLY_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    rx_state_e state_q, state_d;

    logic [10:0]     len_q;
    logic [10:0]     len_inc;
    logic [111:0]    hdr_q;
    logic [4:0][7:0] dl_q;
    logic [2:0]      cnt_q;
    logic            err_q;
    logic            long_q;
    logic            fcs_bad;

    logic [47:0] dest_now;
    logic        start_ok;
    logic        filt_pass;

    logic        emit, emit_last, st_valid;
    logic [7:0]  emit_data;
    logic [2:0]  code_now;
    logic        good_inc, bad_inc, filt_inc;

    logic [7:0]       out_data_q;
    logic             out_valid_q, out_last_q, status_valid_q;
    logic [2:0]       status_code_q;
    logic [10:0]      frame_len_q;
    logic [47:0]      dest_mac_q, src_mac_q;
    logic [15:0]      eth_type_q;
    logic [CNT_W-1:0] cnt_good_q, cnt_bad_q, cnt_filt_q;

    assign len_inc   = (len_q == LEN_SAT) ? len_q : len_q + 11'd1;
    assign dest_now  = {hdr_q[39:0], rx_data_i};
    assign start_ok  = rx_dv_i && rx_enable_i && (rx_data_i == ETH_PREAMBLE);
    assign filt_pass = (dest_now == LOCAL_MAC)
                     || (ACCEPT_BCAST && (dest_now == ETH_BCAST_MAC))
                     || promisc_en_i;

`ifdef ETH_RX_FCS_CHECK_EN
    logic [31:0] crc_q, crc_nx;

    eth_crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i (rx_data_i),
        .crc_o  (crc_nx)
    );

    assign fcs_bad = (crc_q != CRC32_RESIDUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC32_INIT;
        end else if (state_q == ST_PRE) begin
            crc_q <= CRC32_INIT;
        end else if (rx_dv_i && (state_q == ST_HDR || state_q == ST_DATA)) begin
            crc_q <= crc_nx;
        end
    end
`else
    assign fcs_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_dv_i) state_d = start_ok ? ST_PRE : ST_DROP;
            end
            ST_PRE: begin
                if (!rx_dv_i)                       state_d = ST_DROP;
                else if (rx_data_i == ETH_SFD)      state_d = ST_HDR;
                else if (rx_data_i != ETH_PREAMBLE) state_d = ST_DROP;
            end
            ST_HDR: begin
                if (!rx_dv_i)                            state_d = ST_END;
                else if (len_q == LEN_DEST && !filt_pass) state_d = ST_DROP;
                else if (len_q == LEN_HDR)                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (!rx_dv_i) state_d = ST_END;
            end
            ST_END: begin
                // a new preamble may already start during the END cycle
                if (start_ok)     state_d = ST_PRE;
                else if (rx_dv_i) state_d = ST_DROP;
                else              state_d = ST_IDLE;
            end
            ST_DROP: begin
                if (!rx_dv_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if (err_q)                                 code_now = CODE_PHY_ERR;
        else if (long_q)                           code_now = CODE_TOO_LONG;
        else if (len_q < MIN_L || cnt_q != DLY_FULL) code_now = CODE_RUNT;
        else if (fcs_bad)                          code_now = CODE_FCS_ERR;
        else                                       code_now = CODE_OK;
    end

    always_comb begin
        emit      = 1'b0;
        emit_last = 1'b0;
        emit_data = 8'h00;
        st_valid  = 1'b0;
        good_inc  = 1'b0;
        bad_inc   = 1'b0;
        filt_inc  = 1'b0;
        case (state_q)
            ST_PRE: begin
                bad_inc = !rx_dv_i
                        || (rx_data_i != ETH_SFD && rx_data_i != ETH_PREAMBLE);
            end
            ST_HDR: begin
                filt_inc = rx_dv_i && (len_q == LEN_DEST) && !filt_pass;
            end
            ST_DATA: begin
                if (rx_dv_i && cnt_q == DLY_FULL && !long_q && len_inc <= MAX_L) begin
                    emit      = 1'b1;
                    emit_data = dl_q[4];
                end
            end
            ST_END: begin
                emit      = 1'b1;
                emit_last = 1'b1;
                st_valid  = 1'b1;
                emit_data = (cnt_q == DLY_FULL && !long_q) ? dl_q[4] : 8'h00;
                good_inc  = (code_now == CODE_OK);
                bad_inc   = (code_now != CODE_OK);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q  <= '0;
            hdr_q  <= '0;
            dl_q   <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            long_q <= 1'b0;
        end else begin
            case (state_q)
                ST_PRE: begin
                    if (rx_dv_i && rx_data_i == ETH_SFD) begin
                        len_q  <= '0;
                        cnt_q  <= '0;
                        long_q <= 1'b0;
                        err_q  <= rx_err_i;
                    end
                end
                ST_HDR: begin
                    if (rx_dv_i) begin
                        hdr_q <= {hdr_q[103:0], rx_data_i};
                        len_q <= len_inc;
                        err_q <= err_q | rx_err_i;
                    end
                end
                ST_DATA: begin
                    if (rx_dv_i) begin
                        dl_q   <= {dl_q[3:0], rx_data_i};
                        cnt_q  <= (cnt_q == DLY_FULL) ? cnt_q : cnt_q + 3'd1;
                        len_q  <= len_inc;
                        long_q <= long_q | (len_inc > MAX_L);
                        err_q  <= err_q | rx_err_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            status_valid_q <= 1'b0;
            status_code_q  <= '0;
            frame_len_q    <= '0;
            dest_mac_q     <= '0;
            src_mac_q      <= '0;
            eth_type_q     <= '0;
            cnt_good_q     <= '0;
            cnt_bad_q      <= '0;
            cnt_filt_q     <= '0;
        end else begin
            out_data_q     <= emit_data;
            out_valid_q    <= emit;
            out_last_q     <= emit_last;
            status_valid_q <= st_valid;
            if (st_valid) begin
                status_code_q <= code_now;
                frame_len_q   <= len_q;
                dest_mac_q    <= hdr_q[111:64];
                src_mac_q     <= hdr_q[63:16];
                eth_type_q    <= hdr_q[15:0];
            end
            if (good_inc && cnt_good_q != CNT_MAX) cnt_good_q <= cnt_good_q + CNT_ONE;
            if (bad_inc && cnt_bad_q != CNT_MAX)   cnt_bad_q  <= cnt_bad_q + CNT_ONE;
            if (filt_inc && cnt_filt_q != CNT_MAX) cnt_filt_q <= cnt_filt_q + CNT_ONE;
        end
    end

    assign out_data_o     = out_data_q;
    assign out_valid_o    = out_valid_q;
    assign out_last_o     = out_last_q;
    assign status_valid_o = status_valid_q;
    assign status_code_o  = status_code_q;
    assign frame_len_o    = frame_len_q;
    assign dest_mac_o     = dest_mac_q;
    assign src_mac_o      = src_mac_q;
    assign eth_type_o     = eth_type_q;
    assign cnt_good_o     = cnt_good_q;
    assign cnt_bad_o      = cnt_bad_q;
    assign cnt_filt_o     = cnt_filt_q;

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// tb_eth_rx_frame_parser: scoreboard bench for the Ethernet RX parser;
// expected beats/status are queued at drive time and popped at the outputs.
module tb_eth_rx_frame_parser;

    localparam logic [47:0] LOCAL = 48'h0200_0000_0001;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] OTHER = 48'h0200_0000_0099;
`ifdef ETH_RX_FCS_CHECK_EN
    localparam bit FCS_EN = 1'b1;
`else
    localparam bit FCS_EN = 1'b0;
`endif

    typedef struct {
        logic [47:0] dest;
        logic [2:0]  code;
        logic [10:0] len;
        bit          hdr_ok;
    } st_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_dv = 1'b0;
    logic        rx_err = 1'b0;
    logic        rx_enable = 1'b1;
    logic        promisc = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid, out_last, status_valid;
    logic [2:0]  status_code;
    logic [10:0] frame_len;
    logic [47:0] dest_mac, src_mac;
    logic [15:0] eth_type;
    logic [15:0] cnt_good, cnt_bad, cnt_filt;

    int nvec = 0;
    int nerr = 0;
    int exp_good = 0, exp_bad = 0, exp_filt = 0;

    logic [7:0] frm[$];
    logic [8:0] exp_beats[$];
    st_t        exp_st[$];

    always #5 clk = ~clk;

    eth_rx_frame_parser dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data_i      (rx_data),
        .rx_dv_i        (rx_dv),
        .rx_err_i       (rx_err),
        .rx_enable_i    (rx_enable),
        .promisc_en_i   (promisc),
        .out_data_o     (out_data),
        .out_valid_o    (out_valid),
        .out_last_o     (out_last),
        .status_valid_o (status_valid),
        .status_code_o  (status_code),
        .frame_len_o    (frame_len),
        .dest_mac_o     (dest_mac),
        .src_mac_o      (src_mac),
        .eth_type_o     (eth_type),
        .cnt_good_o     (cnt_good),
        .cnt_bad_o      (cnt_bad),
        .cnt_filt_o     (cnt_filt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(logic [31:0] c, logic [7:0] d);
        c = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    task automatic build(input logic [47:0] dst, input int plen, input bit flip);
        logic [31:0] c;
        logic [47:0] s;
        s = 48'h0200_0000_00AA;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(s[47-8*i -: 8]);
        frm.push_back(8'h08);
        frm.push_back(8'h00);
        for (int i = 0; i < plen; i++) frm.push_back(i[7:0]);
        c = 32'hFFFF_FFFF;
        foreach (frm[i]) c = crc_upd(c, frm[i]);
        c = ~c;
        if (flip) c[3] = ~c[3];
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    endtask

    task automatic drive(input logic [7:0] b, input bit e);
        @(negedge clk);
        rx_dv = 1'b1;
        rx_data = b;
        rx_err = e;
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        rx_dv = 1'b0;
        rx_data = 8'h00;
        rx_err = 1'b0;
        repeat (6) @(negedge clk);
        chk({tag, "_good"}, cnt_good, exp_good);
        chk({tag, "_bad"}, cnt_bad, exp_bad);
        chk({tag, "_filt"}, cnt_filt, exp_filt);
    endtask

    task automatic tx(input string tag, input int err_at, input bit bad_fcs);
        int L;
        logic [47:0] d;
        bit pass;
        st_t s;
        L = frm.size();
        d = '0;
        for (int i = 0; i < 6 && i < L; i++) d = {d[39:0], frm[i]};
        pass = promisc || d == LOCAL || d == BCAST || L < 6;
        if (rx_enable) begin
            if (!pass) begin
                exp_filt++;
            end else begin
                if (err_at >= 0 && err_at < L) s.code = 3'd3;
                else if (L > 1518)              s.code = 3'd2;
                else if (L < 64)                s.code = 3'd1;
                else if (bad_fcs && FCS_EN)     s.code = 3'd4;
                else                            s.code = 3'd0;
                s.len = (L > 2047) ? 11'h7FF : 11'(L);
                s.dest = d;
                s.hdr_ok = (L >= 14);
                if (L > 1518) begin
                    for (int i = 14; i <= 1512; i++) exp_beats.push_back({1'b0, frm[i]});
                    exp_beats.push_back(9'h100);
                end else if (L >= 19) begin
                    for (int i = 14; i < L - 5; i++) exp_beats.push_back({1'b0, frm[i]});
                    exp_beats.push_back({1'b1, frm[L-5]});
                end else begin
                    exp_beats.push_back(9'h100);
                end
                exp_st.push_back(s);
                if (s.code == 3'd0) exp_good++;
                else                exp_bad++;
            end
        end
        repeat (7) drive(8'h55, 1'b0);
        drive(8'hD5, 1'b0);
        for (int i = 0; i < L; i++) drive(frm[i], i == err_at);
        idle_chk(tag);
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        st_t s;
        if (out_valid) begin
            if (exp_beats.size() == 0) begin
                chk("beat_extra", {out_last, out_data}, 9'h1FF);
            end else begin
                e = exp_beats.pop_front();
                chk("beat", {out_last, out_data}, e);
            end
        end
        if (status_valid) begin
            chk("st_last", out_last, 1'b1);
            if (exp_st.size() == 0) begin
                chk("status_extra", status_code, 3'h7);
            end else begin
                s = exp_st.pop_front();
                chk("status_code", status_code, s.code);
                chk("frame_len", frame_len, s.len);
                if (s.hdr_ok) chk("dest_mac", dest_mac, s.dest);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_status", status_valid, 1'b0);
        chk("rst_len", frame_len, 11'd0);
        chk("rst_dest", dest_mac, 48'd0);
        chk("rst_cnt", {cnt_good, cnt_bad, cnt_filt}, 48'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        build(LOCAL, 46, 1'b0);   tx("uc64", -1, 1'b0);
        chk("type", eth_type, 16'h0800);
        chk("src", src_mac, 48'h0200_0000_00AA);
        build(OTHER, 46, 1'b0);   tx("filt", -1, 1'b0);
        promisc = 1'b1;
        build(OTHER, 46, 1'b0);   tx("promisc", -1, 1'b0);
        promisc = 1'b0;
        build(BCAST, 50, 1'b0);   tx("bcast", -1, 1'b0);
        build(LOCAL, 42, 1'b0);   tx("runt60", -1, 1'b0);
        build(LOCAL, 46, 1'b0);
        frm = frm[0:9];           tx("cut10", -1, 1'b0);
        build(LOCAL, 1501, 1'b0); tx("long", -1, 1'b0);
        build(LOCAL, 60, 1'b0);   tx("phyerr", 30, 1'b0);
        build(LOCAL, 60, 1'b1);   tx("fcsflip", -1, 1'b1);
        build(LOCAL, 1500, 1'b0); tx("max", -1, 1'b0);

        drive(8'h55, 1'b0);
        drive(8'h55, 1'b0);
        drive(8'h55, 1'b0);
        drive(8'h12, 1'b0);
        exp_bad++;
        idle_chk("prebad");

        rx_enable = 1'b0;
        build(LOCAL, 46, 1'b0);   tx("disabled", -1, 1'b0);
        rx_enable = 1'b1;

        build(LOCAL, 46, 1'b0);
        for (int i = 14; i <= 19; i++) exp_beats.push_back({1'b0, frm[i]});
        repeat (7) drive(8'h55, 1'b0);
        drive(8'hD5, 1'b0);
        for (int i = 0; i < 25; i++) drive(frm[i], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        rx_data = frm[25];
        @(negedge clk);
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_cnt", {cnt_good, cnt_bad, cnt_filt}, 48'd0);
        chk("midrst_dest", dest_mac, 48'd0);
        rx_data = frm[26];
        @(negedge clk);
        rst = 1'b0;
        for (int i = 27; i < 32; i++) drive(frm[i], 1'b0);
        exp_good = 0;
        exp_bad = 0;
        exp_filt = 0;
        idle_chk("postrst");
        build(LOCAL, 46, 1'b0);   tx("after_rst", -1, 1'b0);

        chk("beats_left", exp_beats.size(), 0);
        chk("status_left", exp_st.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
